// File: rtl/axioma_spi_slave.sv
// ---------------------------------------------------------------------------
// axioma_spi_slave
//
// SPI slave peripheral with an AVR-style register interface (SPCR/SPSR/SPDR).
// The external SPI pins are sampled into the clk domain through a short
// synchronizer chain. SCK edges are detected on the synchronized copy, so
// spi_sck must run no faster than clk/8.
//
// Ports
//   clk            system I/O clock
//   reset          synchronous, active-high reset
//   io_addr[5:0]   I/O register address (SPCR 0x2C, SPSR 0x2D, SPDR 0x2E)
//   io_data_in     I/O write data
//   io_data_out    I/O read data (combinational, 0x00 unless a decoded read)
//   io_read        single-cycle read strobe
//   io_write       single-cycle write strobe
//   spi_sck        master clock
//   spi_mosi       master data out
//   spi_ss_n       active-low slave select
//   spi_miso       slave data out (0 while the pad is disabled)
//   spi_miso_oe    MISO pad enable
//   spi_interrupt  level interrupt request (SPIE & SPIF)
//   debug_state    {6'b0, FSM state}
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a falling ss_n with SPE set
//   ACTIVE | clocking bits in/out of the shift register
//   DONE   | byte complete: update RX buffer, TX holding register, flags
// ---------------------------------------------------------------------------
module axioma_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] io_addr,
    input  logic [7:0] io_data_in,
    output logic [7:0] io_data_out,
    input  logic       io_read,
    input  logic       io_write,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_ss_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       spi_interrupt,
    output logic [7:0] debug_state
);

    localparam logic [5:0] ADDR_SPCR = 6'h2C;
    localparam logic [5:0] ADDR_SPSR = 6'h2D;
    localparam logic [5:0] ADDR_SPDR = 6'h2E;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Pin synchronizers
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   ss_s;
    logic                   sck_prev;
    logic                   ss_prev;

    // Control register fields
    logic spie;
    logic spe;
    logic dord;
    logic cpol;
    logic cpha;

    // Status flags
    logic spif;
    logic wcol;
    logic ovr;
    // Set by an SPSR read that saw SPIF=1; the next SPDR access clears flags.
    logic spsr_armed;

    // Data path
    logic [7:0] rx_buf;
    logic [7:0] tx_hold;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       rx_bit;

    // Decode and edge detection
    logic sel_spcr;
    logic sel_spsr;
    logic sel_spdr;
    logic spdr_access;
    logic sck_rise;
    logic sck_fall;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic ss_fall;

    // FSM controls
    logic start_xfer;
    logic take_sample;
    logic take_shift;
    logic last_sample;
    logic byte_done;

    logic [7:0] spcr_val;
    logic [7:0] spsr_val;

    // -----------------------------------------------------------------------
    // Synchronizers: preset to the idle bus (ss_n high, sck/mosi low) so that
    // reset release never looks like a select or clock edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sck_prev  <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sck_sync[0]  <= spi_sck;
            mosi_sync[0] <= spi_mosi;
            ss_sync[0]   <= spi_ss_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
                ss_sync[i]   <= ss_sync[i-1];
            end
            sck_prev <= sck_s;
            ss_prev  <= ss_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];

    assign sck_rise    = sck_s & ~sck_prev;
    assign sck_fall    = ~sck_s & sck_prev;
    assign lead_edge   = cpol ? sck_fall : sck_rise;
    assign trail_edge  = cpol ? sck_rise : sck_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_s & ss_prev;

    assign sel_spcr    = (io_addr == ADDR_SPCR);
    assign sel_spsr    = (io_addr == ADDR_SPSR);
    assign sel_spdr    = (io_addr == ADDR_SPDR);
    assign spdr_access = (io_read | io_write) & sel_spdr;

    assign spcr_val = {spie, spe, dord, 1'b0, cpol, cpha, 2'b00};
    assign spsr_val = {spif, wcol, ovr, 5'b00000};

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A shift is only taken once at least one bit has been sampled. In CPHA=1
    // this skips the first leading edge (bit 7/0 is already on MISO after the
    // load); in CPHA=0 it swallows the 8th trailing edge that arrives after a
    // back-to-back reload.
    always_comb begin
        state_nxt   = state;
        start_xfer  = 1'b0;
        take_sample = 1'b0;
        take_shift  = 1'b0;
        last_sample = 1'b0;
        byte_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (spe && ss_fall) begin
                    state_nxt  = ST_ACTIVE;
                    start_xfer = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!spe || ss_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    take_sample = sample_edge;
                    take_shift  = shift_edge && (bit_cnt != 3'd0);
                    if (sample_edge && (bit_cnt == 3'd7)) begin
                        last_sample = 1'b1;
                        state_nxt   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                byte_done = 1'b1;
                state_nxt = ss_s ? ST_IDLE : ST_ACTIVE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Shift register and bit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
            rx_bit    <= 1'b0;
        end else if (start_xfer) begin
            shift_reg <= tx_hold;
            bit_cnt   <= 3'd0;
        end else if (take_sample) begin
            rx_bit  <= mosi_s;
            bit_cnt <= bit_cnt + 3'd1;
            // The 8th bit never gets its own shift edge, so fold it in here to
            // leave the completed byte in the shift register for DONE.
            if (last_sample) begin
                shift_reg <= dord ? {mosi_s, shift_reg[7:1]} : {shift_reg[6:0], mosi_s};
            end
        end else if (take_shift) begin
            shift_reg <= dord ? {rx_bit, shift_reg[7:1]} : {shift_reg[6:0], rx_bit};
        end else if (byte_done) begin
            // DONE copies the shift register into the TX holding register, so
            // the reload for a back-to-back byte is the value already held.
            bit_cnt <= 3'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Registers and flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            spie       <= 1'b0;
            spe        <= 1'b0;
            dord       <= 1'b0;
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            rx_buf     <= 8'h00;
            tx_hold    <= 8'h00;
            spif       <= 1'b0;
            wcol       <= 1'b0;
            ovr        <= 1'b0;
            spsr_armed <= 1'b0;
        end else begin
            if (io_write && sel_spcr) begin
                spie <= io_data_in[7];
                spe  <= io_data_in[6];
                dord <= io_data_in[5];
                cpol <= io_data_in[3];
                cpha <= io_data_in[2];
            end

            if (io_write && sel_spdr && (state == ST_IDLE)) begin
                tx_hold <= io_data_in;
            end

            // Clearing comes first so that any set in the same cycle wins.
            if (spdr_access) begin
                spsr_armed <= 1'b0;
                if (spsr_armed) begin
                    spif <= 1'b0;
                    wcol <= 1'b0;
                    ovr  <= 1'b0;
                end
            end

            if (io_read && sel_spsr && spif) begin
                spsr_armed <= 1'b1;
            end

            if (io_write && sel_spdr && (state != ST_IDLE)) begin
                wcol <= 1'b1;
            end

            if (byte_done) begin
                rx_buf  <= shift_reg;
                tx_hold <= shift_reg;
                spif    <= 1'b1;
                if (spif) begin
                    ovr <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        io_data_out = 8'h00;
        if (io_read && !reset) begin
            case (io_addr)
                ADDR_SPCR: io_data_out = spcr_val;
                ADDR_SPSR: io_data_out = spsr_val;
                ADDR_SPDR: io_data_out = rx_buf;
                default:   io_data_out = 8'h00;
            endcase
        end
    end

    assign spi_miso_oe   = ~reset & spe & ~ss_s;
    assign spi_miso      = spi_miso_oe & (dord ? shift_reg[0] : shift_reg[7]);
    assign spi_interrupt = ~reset & spie & spif;
    assign debug_state   = {6'b000000, state};

endmodule

// File: doc/axioma_spi_slave.md
AXIOMA_SPI_SLAVE -- requirements
Module: axioma_spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth for spi_sck, spi_mosi and spi_ss_n.
REQ-002 SHALL have port clk  input  1  system I/O clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous to clk, active-high.
REQ-004 SHALL have port io_addr  input  6  I/O register address.
REQ-005 SHALL have port io_data_in  input  8  I/O write data.
REQ-006 SHALL have port io_data_out  output  8  I/O read data.
REQ-007 SHALL have ports io_read and io_write  input  1  single-cycle access strobes.
REQ-008 SHALL have ports spi_sck, spi_mosi, spi_ss_n  input  1  external master clock, data and active-low select.
REQ-009 SHALL have port spi_miso  output  1  slave data out.
REQ-010 SHALL have port spi_miso_oe  output  1  MISO pad enable.
REQ-011 SHALL have port spi_interrupt  output  1  level interrupt request.
REQ-012 SHALL have port debug_state  output  8  {6'b0, FSM state}.

Function
REQ-013 SHALL decode registers: SPCR 0x2C, SPSR 0x2D, SPDR 0x2E; other addresses are ignored, and reads of them return 0x00.
REQ-014 SPCR bits SHALL be: 7 SPIE, 6 SPE, 5 DORD (1 = LSB first), 3 CPOL, 2 CPHA; bits 4,1,0 SHALL read 0 and ignore writes.
REQ-015 SPSR bits SHALL be: 7 SPIF, 6 WCOL, 5 OVR, rest 0; SPSR SHALL be read-only.
REQ-016 io_data_out SHALL be combinational: selected register when io_read and address is decoded, else 0x00.
REQ-017 SPI inputs SHALL pass through SYNC_STAGES flops; SCK edges SHALL be detected from the synchronized signal; the spi_sck frequency limit SHALL be clk/8.
REQ-018 Leading edge SHALL be rising when CPOL=0 and falling when CPOL=1; CPHA=0 samples on leading and shifts on trailing; CPHA=1 shifts on leading and samples on trailing.
REQ-019 FSM states SHALL be IDLE(0), ACTIVE(1), DONE(2).
REQ-020 FSM transitions SHALL be:
- IDLE->ACTIVE when SPE=1 and synchronized ss_n falls; the shift register loads from the TX holding register and the bit counter loads 0.
- ACTIVE->DONE on the 8th sample.
- DONE->ACTIVE after one cycle if ss_n is low; otherwise DONE->IDLE.
REQ-021 In DONE, the shifted byte SHALL be copied to the RX buffer and to the TX holding register, and SPIF SHALL be set; if SPIF was already 1, OVR SHALL set and the RX buffer SHALL be overwritten.
REQ-022 For back-to-back bytes under sustained ss_n low, the shift register SHALL reload from the TX holding register on DONE->ACTIVE.
REQ-023 SPIF SHALL rise no later than 4 clk after the pin-level 8th sampling SCK edge.
REQ-024 spi_miso SHALL equal shift[7] (DORD=0) or shift[0] (DORD=1) when spi_miso_oe=1, else 0.
REQ-025 spi_miso_oe SHALL be SPE and not synchronized ss_n.
REQ-026 With CPHA=0, the first bit SHALL be valid on MISO from the cycle after entering ACTIVE.
REQ-027 SPDR write in IDLE SHALL load the TX holding register.
REQ-028 SPDR write in ACTIVE or DONE SHALL set WCOL and be discarded.
REQ-029 SPDR read SHALL return the RX buffer.
REQ-030 After an SPSR read that returns SPIF=1, the next SPDR access SHALL clear SPIF, WCOL and OVR.
REQ-031 On an SPSR read coincident with a DONE set, the set SHALL win.
REQ-032 A synchronized ss_n rise in ACTIVE, or SPE cleared in ACTIVE, SHALL abort to IDLE with no SPIF, no RX buffer update and no TX holding change.
REQ-033 While SPE=0, SCK and MOSI SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-034 spi_interrupt SHALL be SPIE & SPIF.

Reset
REQ-035 On reset, all registers, the RX buffer, the TX holding register, the shift register and the bit counter SHALL clear to 0x00, and the FSM SHALL enter IDLE.
REQ-036 On reset, synchronizers SHALL preset to ss_n=1, sck=0, mosi=0.
REQ-037 During and after reset, spi_miso, spi_miso_oe, spi_interrupt and io_data_out SHALL be 0.
REQ-038 Reset asserted mid-transfer SHALL take priority and discard the byte.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Mode 0, SPCR=0xC0, SPDR=0xA5, master sends 0x3C -> MISO shifts 0xA5 MSB-first, SPIF=1, spi_interrupt=1, SPDR reads 0x3C.
- Mode 3, DORD=1, SPDR=0x01, master sends 0x80 -> MISO sequence 1,0,0,0,0,0,0,0; SPDR reads 0x80.
- Two bytes 0x11, 0x22 under one ss_n low with no SPSR/SPDR access -> second MISO byte echoes 0x11, OVR=1, SPDR=0x22.
- SPDR write during ACTIVE -> WCOL=1, TX unchanged; SPSR read then SPDR read -> SPSR=0x00.
- ss_n rise after 5 bits -> IDLE, SPIF=0, SPDR unchanged; next full transfer is correct.
- SPE=0 with SCK toggling -> spi_miso_oe=0, debug_state=0, no flag changes.
